// File: rtl/main_mem_responder_pkg.sv
// Shared types and constants for the main memory responder (port ids, latency bound, pipeline entry).
// Used by main_mem_responder and mem_resp_arbiter.
package main_mem_responder_pkg;

    localparam logic MEM_PORT_IF          = 1'b0;
    localparam logic MEM_PORT_D           = 1'b1;
    localparam int   MEM_RESP_MAX_LATENCY = 4;
    localparam int   MEM_ADDR_W           = 32;
    localparam int   MEM_WORD_W           = 32;

    typedef enum logic {
        PORT_IF = MEM_PORT_IF,
        PORT_D  = MEM_PORT_D
    } mem_port_e;

    // Payload carried down the latency pipeline alongside its valid bit
    typedef struct packed {
        mem_port_e             port;
        logic                  err;
        logic [MEM_WORD_W-1:0] data;
    } rsp_meta_t;

endpackage

// File: rtl/mem_resp_arbiter.sv
// Two-way round-robin arbiter between the fetch and data request ports.
// Holds last_grant; a tie goes to the port that was not granted last.
module mem_resp_arbiter
    import main_mem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      if_valid,
    input  logic      d_valid,
    output logic      grant_valid,
    output mem_port_e grant_port,
    output logic      if_ready,
    output logic      d_ready
);

    mem_port_e last_grant;

    always_comb begin
        grant_valid = !rst && (if_valid || d_valid);
        grant_port  = PORT_IF;
        if (if_valid && d_valid) begin
            grant_port = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_valid) begin
            grant_port = PORT_D;
        end
        if_ready = grant_valid && (grant_port == PORT_IF);
        d_ready  = grant_valid && (grant_port == PORT_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_D;
        end else if (grant_valid) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Single-port word memory serving fetch and load/store requests with fixed-latency responses.
// Optional MAIN_MEM_RESP_ERR_EN: out-of-range addresses are flagged instead of wrapping.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic                  grant_valid;
    mem_port_e             grant_port;
    logic [MEM_ADDR_W-1:0] req_addr;
    logic [AW-1:0]         req_idx;
    logic                  req_store;
    logic                  req_oor;

    logic [MEM_WORD_W-1:0] mem [DEPTH];

    logic      vld_p  [LATENCY];
    rsp_meta_t meta_p [LATENCY];

    mem_resp_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_req_valid),
        .d_valid     (d_req_valid),
        .grant_valid (grant_valid),
        .grant_port  (grant_port),
        .if_ready    (if_req_ready),
        .d_ready     (d_req_ready)
    );

    always_comb begin
        req_addr  = (grant_port == PORT_D) ? d_req_addr : if_req_addr;
        req_idx   = req_addr[AW-1:0];
        req_store = grant_valid && (grant_port == PORT_D) && d_req_we;
    end

`ifdef MAIN_MEM_RESP_ERR_EN
    assign req_oor = |req_addr[MEM_ADDR_W-1:AW];
`else
    // Upper bits are deliberately ignored so the address wraps modulo DEPTH
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[MEM_ADDR_W-1:AW];
    assign req_oor        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (req_store && !req_oor) begin
            mem[req_idx] <= d_req_wdata;
        end
    end

    // Stage p0: array read at the accepting edge; stores and out-of-range reads carry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p[0] <= 1'b0;
        end else begin
            vld_p[0] <= grant_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_valid) begin
            meta_p[0].port <= grant_port;
            meta_p[0].err  <= req_oor;
            meta_p[0].data <= (req_store || req_oor) ? '0 : mem[req_idx];
        end
    end

    // Stages p1..p(LATENCY-1): pure delay line, reset clears only the valids
    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p[i] <= 1'b0;
            end else begin
                vld_p[i] <= vld_p[i-1];
            end
        end

        always_ff @(posedge clk) begin
            meta_p[i] <= meta_p[i-1];
        end
    end

    // Response demux from the last stage; data and err are forced to 0 when not valid
    always_comb begin
        if_rsp_valid = vld_p[LATENCY-1] && (meta_p[LATENCY-1].port == PORT_IF);
        d_rsp_valid  = vld_p[LATENCY-1] && (meta_p[LATENCY-1].port == PORT_D);
        if_rsp_data  = if_rsp_valid ? meta_p[LATENCY-1].data : '0;
        if_rsp_err   = if_rsp_valid && meta_p[LATENCY-1].err;
        d_rsp_data   = d_rsp_valid ? meta_p[LATENCY-1].data : '0;
        d_rsp_err    = d_rsp_valid && meta_p[LATENCY-1].err;
    end

endmodule
